// File: rtl/fmem_pkg.sv
// Shared frame-memory definitions: pixel type, field offsets inside a 2x2
// block word, and the raster-reader state encoding.
package fmem_pkg;

  localparam int PIX_W  = 24;
  typedef logic [PIX_W-1:0] pixel_t;

  // Bit offsets of each pixel inside a 96-bit block word
  localparam int PIX_TL = 72;
  localparam int PIX_TR = 48;
  localparam int PIX_BL = 24;
  localparam int PIX_BR = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_EVEN0,
    ST_EVEN1,
    ST_ODD,
    ST_FIN
  } state_e;

endpackage

// File: rtl/fmem_line_buf.sv
// Holds the lower-row pixel pair of every block in the current block row:
// one synchronous write port, one combinational read port, no reset.
module fmem_line_buf #(
  parameter int DEPTH = 160,
  parameter int AW    = 8,
  parameter int W     = 48
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fmem_raster_reader.sv
// Reads the block-organised frame buffer once per word and streams pixels
// in raster order; lower rows are replayed from the line buffer.
module fmem_raster_reader
  import fmem_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_DEPTH = 65536,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int HRES       = 320,
  parameter int VRES       = 240
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CSN,
  output logic                  WEN,
  output logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DOUT,
  output logic                  PIX_VALID,
  input  logic                  PIX_READY,
  output logic [PIX_W-1:0]      PIX_DATA,
  output logic                  PIX_SOF,
  output logic                  PIX_EOL
);

  localparam int HB = HRES / 2;
  localparam int VB = VRES / 2;
  localparam int CW = (HB > 1) ? $clog2(HB) : 1;
  localparam int RW = (VB > 1) ? $clog2(VB) : 1;
  localparam int XW = CW + 1;
  localparam logic [CW-1:0]         C_LAST   = CW'(HB - 1);
  localparam logic [RW-1:0]         R_LAST   = RW'(VB - 1);
  localparam logic [XW-1:0]         X_LAST   = XW'(HRES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(HB);

  state_e                state_q;
  logic [CW-1:0]         c_q;
  logic [RW-1:0]         r_q;
  logic [XW-1:0]         x_q;
  logic [ADDR_WIDTH-1:0] base_q;
  pixel_t                tr_q;
  logic                  csn_q, busy_q, done_q, valid_q, sof_q, eol_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  pixel_t                data_q;

  logic [CW-1:0]         c_inc;
  logic [XW-1:0]         x_nxt;
  logic [CW-1:0]         lb_raddr;
  logic                  lb_lo;
  logic [2*PIX_W-1:0]    lb_rdata;
  pixel_t                lb_pix;

  assign c_inc = c_q + 1'b1;
  assign x_nxt = x_q + 1'b1;

  // Outside ODD the read port points at entry 0 so the first odd-row pixel
  // is ready when EVEN1 hands over.
  always_comb begin
    lb_raddr = '0;
    lb_lo    = 1'b0;
    if (state_q == ST_ODD) begin
      lb_raddr = x_nxt[CW:1];
      lb_lo    = x_nxt[0];
    end
  end

  assign lb_pix = lb_lo ? lb_rdata[PIX_W-1:0] : lb_rdata[2*PIX_W-1:PIX_W];

  fmem_line_buf #(
    .DEPTH(HB),
    .AW   (CW),
    .W    (2*PIX_W)
  ) u_line_buf (
    .clk_i  (CLK),
    .we_i   (state_q == ST_RD_WAIT),
    .waddr_i(c_q),
    .wdata_i(DOUT[PIX_BL+PIX_W-1:PIX_BR]),
    .raddr_i(lb_raddr),
    .rdata_o(lb_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      r_q     <= '0;
      x_q     <= '0;
      base_q  <= '0;
      tr_q    <= '0;
      csn_q   <= 1'b1;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (START) begin
          c_q     <= '0;
          r_q     <= '0;
          base_q  <= '0;
          addr_q  <= '0;
          csn_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_RD_REQ;
        end
        ST_RD_REQ: begin
          csn_q   <= 1'b1;
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          tr_q    <= DOUT[PIX_TR+:PIX_W];
          data_q  <= DOUT[PIX_TL+:PIX_W];
          valid_q <= 1'b1;
          sof_q   <= (r_q == '0) && (c_q == '0);
          eol_q   <= 1'b0;
          state_q <= ST_EVEN0;
        end
        ST_EVEN0: if (PIX_READY) begin
          data_q  <= tr_q;
          sof_q   <= 1'b0;
          eol_q   <= (c_q == C_LAST);
          state_q <= ST_EVEN1;
        end
        ST_EVEN1: if (PIX_READY) begin
          eol_q <= 1'b0;
          if (c_q != C_LAST) begin
            c_q     <= c_inc;
            addr_q  <= base_q + ADDR_WIDTH'(c_inc);
            csn_q   <= 1'b0;
            valid_q <= 1'b0;
            state_q <= ST_RD_REQ;
          end else begin
            c_q     <= '0;
            x_q     <= '0;
            data_q  <= lb_pix;
            state_q <= ST_ODD;
          end
        end
        ST_ODD: if (PIX_READY) begin
          if (x_q != X_LAST) begin
            x_q    <= x_nxt;
            data_q <= lb_pix;
            eol_q  <= (x_nxt == X_LAST);
          end else begin
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            if (r_q != R_LAST) begin
              r_q     <= r_q + 1'b1;
              base_q  <= base_q + ROW_STEP;
              addr_q  <= base_q + ROW_STEP;
              csn_q   <= 1'b0;
              state_q <= ST_RD_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign WEN       = 1'b1;
  assign CSN       = csn_q;
  assign ADDR      = addr_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PIX_VALID = valid_q;
  assign PIX_DATA  = data_q;
  assign PIX_SOF   = sof_q;
  assign PIX_EOL   = eol_q;

endmodule

// File: tb/tb_fmem_raster_reader.sv
// Directed bench: an 8x4 instance for protocol corner cases and a full-width
// 320x8 instance, both fed by a one-cycle-latency SRAM model.
module tb_fmem_raster_reader;

  localparam int SH = 8;
  localparam int SV = 4;
  localparam int LH = 320;
  localparam int LV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic        s_start, s_busy, s_done, s_csn, s_wen, s_valid, s_sof, s_eol;
  logic [15:0] s_addr;
  logic [95:0] s_dout = '0;
  logic [23:0] s_data;
  logic        l_start, l_busy, l_done, l_csn, l_wen, l_valid, l_sof, l_eol;
  logic [15:0] l_addr;
  logic [95:0] l_dout = '0;
  logic [23:0] l_data;

  logic [95:0] s_mem [SH*SV/4];
  logic [95:0] l_mem [LH*LV/4];

  assign s_start = start & ~sel;
  assign l_start = start & sel;

  always @(posedge clk) begin
    if (!s_csn) s_dout <= s_mem[s_addr[2:0]];
    if (!l_csn) l_dout <= l_mem[l_addr[9:0]];
  end

  logic        o_busy, o_done, o_csn, o_wen, o_valid, o_sof, o_eol;
  logic [15:0] o_addr;
  logic [23:0] o_data;
  assign o_busy  = sel ? l_busy  : s_busy;
  assign o_done  = sel ? l_done  : s_done;
  assign o_csn   = sel ? l_csn   : s_csn;
  assign o_wen   = sel ? l_wen   : s_wen;
  assign o_valid = sel ? l_valid : s_valid;
  assign o_sof   = sel ? l_sof   : s_sof;
  assign o_eol   = sel ? l_eol   : s_eol;
  assign o_addr  = sel ? l_addr  : s_addr;
  assign o_data  = sel ? l_data  : s_data;

  fmem_raster_reader #(.HRES(SH), .VRES(SV)) u_small (
    .CLK(clk), .RST(rst), .START(s_start), .BUSY(s_busy), .DONE(s_done),
    .CSN(s_csn), .WEN(s_wen), .ADDR(s_addr), .DOUT(s_dout),
    .PIX_VALID(s_valid), .PIX_READY(ready), .PIX_DATA(s_data),
    .PIX_SOF(s_sof), .PIX_EOL(s_eol)
  );

  fmem_raster_reader #(.HRES(LH), .VRES(LV)) u_large (
    .CLK(clk), .RST(rst), .START(l_start), .BUSY(l_busy), .DONE(l_done),
    .CSN(l_csn), .WEN(l_wen), .ADDR(l_addr), .DOUT(l_dout),
    .PIX_VALID(l_valid), .PIX_READY(ready), .PIX_DATA(l_data),
    .PIX_SOF(l_sof), .PIX_EOL(l_eol)
  );

  function automatic logic [95:0] mkword(input int k);
    return {24'(4*k), 24'(4*k+1), 24'(4*k+2), 24'(4*k+3)};
  endfunction

  // Expected image: pixel (y,x) lives in word (y/2)*(h/2)+x/2 at slot 2*(y%2)+(x%2)
  function automatic int exp_pix(input int y, input int x, input int h);
    return 4*((y/2)*(h/2) + x/2) + 2*(y%2) + (x%2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one frame and consumes it; optional pseudo-random READY, START
  // pulses while busy / during DONE, or a reset once abort_at pixels are taken.
  task automatic run_frame(input int h, input int v, input bit rnd,
                           input int abort_at, input bit restart);
    int n, nrd, cyc, first_cyc, last_hs, done_cnt, done_cyc, last_addr, lim;
    bit stalled;
    logic [25:0] prev;
    n = 0; nrd = 0; first_cyc = -1; last_hs = -10; done_cnt = 0;
    done_cyc = 0; last_addr = -1; stalled = 1'b0; prev = '0;
    lim = h*v*4 + 200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < lim && (done_cnt == 0 || cyc < done_cyc + 4)) begin
      if (cyc == 1) chk("busy_after_start", 32'(o_busy), 1);
      if (o_csn === 1'b0) begin
        chk("rd_addr", 32'(o_addr), nrd);
        last_addr = int'(o_addr);
        nrd++;
      end
      if (stalled) begin
        chk("stall_valid", 32'(o_valid), 1);
        chk("stall_hold", 32'({o_sof, o_eol, o_data}), 32'(prev));
        chk("stall_csn", 32'(o_csn), 1);
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_latency", cyc, last_hs + 1);
      end
      if (o_valid === 1'b1 && first_cyc < 0) begin
        first_cyc = cyc;
        chk("first_latency", cyc, 3);
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = restart && (n == 5 || o_done === 1'b1);
      if (o_valid === 1'b1 && ready) begin
        chk("pix_data", 32'(o_data), exp_pix(n / h, n % h, h));
        chk("pix_sof", 32'(o_sof), 32'(n == 0));
        chk("pix_eol", 32'(o_eol), 32'((n % h) == h - 1));
        n++;
        last_hs = cyc;
      end
      stalled = (o_valid === 1'b1) && !ready;
      prev = {o_sof, o_eol, o_data};
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_csn", 32'(o_csn), 1);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_addr", 32'(o_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("pix_count", n, h*v);
    chk("read_count", nrd, h*v/4);
    chk("last_addr", last_addr, h*v/4 - 1);
    chk("done_count", done_cnt, 1);
    chk("busy_end", 32'(o_busy), 0);
    chk("wen_high", 32'(o_wen), 1);
  endtask

  initial begin
    for (int k = 0; k < SH*SV/4; k++) s_mem[k] = mkword(k);
    for (int k = 0; k < LH*LV/4; k++) l_mem[k] = mkword(k);
    repeat (3) @(negedge clk);
    chk("rst_csn0", 32'(o_csn), 1);
    chk("rst_wen0", 32'(o_wen), 1);
    chk("rst_addr0", 32'(o_addr), 0);
    chk("rst_busy0", 32'(o_busy), 0);
    chk("rst_done0", 32'(o_done), 0);
    chk("rst_valid0", 32'(o_valid), 0);
    chk("rst_sof0", 32'(o_sof), 0);
    chk("rst_eol0", 32'(o_eol), 0);
    chk("rst_data0", 32'(o_data), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_csn", 32'(o_csn), 1);

    run_frame(SH, SV, 1'b0, -1, 1'b0);   // ready held high
    run_frame(SH, SV, 1'b1, -1, 1'b0);   // ready toggling
    run_frame(SH, SV, 1'b0, -1, 1'b1);   // START while busy and during DONE
    run_frame(SH, SV, 1'b0, 20, 1'b0);   // reset in second block row
    run_frame(SH, SV, 1'b0, -1, 1'b0);   // clean frame after reset
    sel = 1'b1;
    @(negedge clk);
    run_frame(LH, LV, 1'b0, -1, 1'b0);   // full 320-pixel lines

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
